// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// memory RW convention and the big-endian byte-lane helper.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_WRITE     = 2'd2,
    ST_FINISH    = 2'd3
  } state_e;

  localparam logic MEM_RW_READ  = 1'b0;
  localparam logic MEM_RW_WRITE = 1'b1;

  localparam int DEFAULT_MEM_BYTES = 256;

  // Byte for a lane, lane 0 being the most significant byte (lowest address).
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[8*(3-lane) +: 8];
  endfunction

endpackage

// File: rtl/imem_byte_serializer.sv
// Holds one captured program word and walks its four bytes MSB first.
// The output byte is registered, so it holds the last lane once advancing stops.
module imem_byte_serializer
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_adv,
  output logic [1:0]  o_lane,
  output logic [7:0]  o_byte
);

  logic [31:0] r_word;
  logic [1:0]  r_lane;
  logic [7:0]  r_byte;

  // Capture a word on load, step to the next lane on advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= '0;
      r_lane <= '0;
      r_byte <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_lane <= 2'd0;
      r_byte <= be_byte(i_word, 2'd0);
    end else if (i_adv) begin
      r_lane <= r_lane + 2'd1;
      r_byte <= be_byte(r_word, r_lane + 2'd1);
    end
  end

  assign o_lane = r_lane;
  assign o_byte = r_byte;

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit program words into a byte-addressed big-endian memory,
// one byte write per cycle, with alignment and overrun protection.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic             in_valid,
  input  logic [31:0]      in_word,
  input  logic             in_last,
  output logic             in_ready,
  output logic             mem_RW,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  state_e           r_state;
  state_e           w_next;
  logic [31:0]      r_ptr;
  logic [31:0]      r_mem_addr;
  logic             r_last;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [CNT_W-1:0] r_words;

  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic        w_start_ok;
  logic        w_start_bad;
  logic        w_accept;
  logic        w_overrun_hit;
  logic        w_lane_end;
  logic        w_adv;
  logic        w_overrun;
  logic [32:0] w_word_end;

  // 33-bit sum so a pointer near 2^32 cannot wrap past the bound check.
  assign w_word_end = {1'b0, r_ptr} + 33'd3;
  assign w_overrun  = w_word_end > 33'(MEM_BYTES - 1);
  assign w_adv      = (r_state == ST_WRITE) && (w_lane != 2'd3);

  imem_byte_serializer u_ser (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_load  (w_accept),
    .i_word  (in_word),
    .i_adv   (w_adv),
    .o_lane  (w_lane),
    .o_byte  (w_byte)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode and single-cycle event strobes.
  always_comb begin
    w_next        = r_state;
    w_start_ok    = 1'b0;
    w_start_bad   = 1'b0;
    w_accept      = 1'b0;
    w_overrun_hit = 1'b0;
    w_lane_end    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (base_addr[1:0] != 2'b00) begin
            w_start_bad = 1'b1;
            w_next      = ST_FINISH;
          end else begin
            w_start_ok = 1'b1;
            w_next     = ST_WAIT_WORD;
          end
        end
      end
      ST_WAIT_WORD: begin
        if (in_valid) begin
          if (w_overrun) begin
            w_overrun_hit = 1'b1;
            w_next        = ST_FINISH;
          end else begin
            w_accept = 1'b1;
            w_next   = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (w_lane == 2'd3) begin
          w_lane_end = 1'b1;
          w_next     = r_last ? ST_FINISH : ST_WAIT_WORD;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Pointer, status and output-address registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ptr      <= '0;
      r_mem_addr <= '0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_words    <= '0;
    end else begin
      r_done <= (w_next == ST_FINISH);
      if (w_start_ok) begin
        r_ptr   <= base_addr;
        r_words <= '0;
        r_error <= 1'b0;
        r_busy  <= 1'b1;
      end
      if (w_start_bad || w_overrun_hit) r_error <= 1'b1;
      if (w_next == ST_FINISH) r_busy <= 1'b0;
      if (w_accept) begin
        r_last     <= in_last;
        r_mem_addr <= r_ptr;
      end
      if (r_state == ST_WRITE) begin
        r_ptr <= r_ptr + 32'd1;
        // Address stops advancing after lane 3 so it holds the last byte written.
        if (w_adv) r_mem_addr <= r_ptr + 32'd1;
      end
      if (w_lane_end) r_words <= r_words + CNT_W'(1);
    end
  end

  assign in_ready      = (r_state == ST_WAIT_WORD);
  assign mem_RW        = (r_state == ST_WRITE) ? MEM_RW_WRITE : MEM_RW_READ;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = w_byte;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign words_written = r_words;

endmodule
